alloc_test: RTL and testbench

ALLOC_TEST -- requirements
Module: alloc_test

---
 rtl/alloc_test_pkg.sv | 69 ++++++
 rtl/alloc_test_alloc.sv | 142 ++++++++++++++
 rtl/alloc_test.sv | 143 ++++++++++++++
 tb/tb_alloc_test.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alloc_test_pkg.sv
// Shared definitions for the allocator self-test: the NIL address, allocator
// command opcodes, test FSM states, o_debug field offsets and the script ROM.
package alloc_test_pkg;

  // Address 0 terminates the free list and is never handed out.
  localparam int unsigned NIL       = 0;
  localparam int unsigned NUM_STEPS = 10;

  // o_debug field offsets (each field is 8/16/32 bits wide).
  localparam int unsigned DBG_STEP_LSB  = 56;
  localparam int unsigned DBG_STATE_LSB = 48;
  localparam int unsigned DBG_ADDR_LSB  = 32;
  localparam int unsigned DBG_DATA_LSB  = 0;

  typedef enum logic [2:0] {
    OP_NOP,
    OP_ALLOC,
    OP_FREE,
    OP_READ,
    OP_WRITE
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_DONE,
    S_FAIL
  } state_e;

  // One script entry. For ALLOC, exp holds the expected address; for READ,
  // the expected data; FREE/WRITE are not checked.
  typedef struct packed {
    op_e         op;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } step_t;

  function automatic step_t mk_step(input op_e op, input logic [7:0] addr,
                                    input logic [31:0] data, input logic [31:0] exp);
    step_t s;
    s.op   = op;
    s.addr = addr;
    s.data = data;
    s.exp  = exp;
    return s;
  endfunction

  function automatic step_t script_step(input logic [3:0] idx);
    step_t s;
    case (idx)
      4'd0:    s = mk_step(OP_ALLOC, 8'h00, 32'h1111_1111, 32'h0000_0001);
      4'd1:    s = mk_step(OP_ALLOC, 8'h00, 32'h2222_2222, 32'h0000_0002);
      4'd2:    s = mk_step(OP_READ,  8'h01, 32'h0000_0000, 32'h1111_1111);
      4'd3:    s = mk_step(OP_FREE,  8'h01, 32'h0000_0000, 32'h0000_0000);
      4'd4:    s = mk_step(OP_ALLOC, 8'h00, 32'h3333_3333, 32'h0000_0001);
      4'd5:    s = mk_step(OP_ALLOC, 8'h00, 32'h4444_4444, 32'h0000_0003);
      4'd6:    s = mk_step(OP_READ,  8'h02, 32'h0000_0000, 32'h2222_2222);
      4'd7:    s = mk_step(OP_READ,  8'h01, 32'h0000_0000, 32'h3333_3333);
      4'd8:    s = mk_step(OP_WRITE, 8'h03, 32'h5555_5555, 32'h0000_0000);
      4'd9:    s = mk_step(OP_READ,  8'h03, 32'h0000_0000, 32'h5555_5555);
      default: s = mk_step(OP_NOP,   8'h00, 32'h0000_0000, 32'h0000_0000);
    endcase
    return s;
  endfunction

endpackage

// File: rtl/alloc_test_alloc.sv
// alloc: free-list cell allocator over a 2^ADDR_W x DATA_W memory.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/op/addr/data   one command per cycle, taken when ready is high
//   ready                    low while a reuse ALLOC is finishing its second cycle
//   rsp_valid                one-cycle pulse when a command completes
//   rsp_addr                 address returned by ALLOC (NIL when exhausted)
//   rsp_data                 data returned by READ
module alloc
  import alloc_test_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              ready,
  output logic              rsp_valid,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_data
);

  localparam logic [ADDR_W-1:0] NIL_A   = ADDR_W'(NIL);
  localparam logic [ADDR_W:0]   TOP_ONE = (ADDR_W+1)'(1);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] mem_q;

  logic [ADDR_W-1:0] head;
  // One bit wider than an address so that the last cell can be handed out
  // and exhaustion shows up as the carry bit.
  logic [ADDR_W:0]   top;

  logic              pend;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_data;

  op_e               op;
  logic              accept;
  logic              full;
  logic              list_empty;

  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_wa;
  logic [ADDR_W-1:0] mem_ra;
  logic [DATA_W-1:0] mem_wd;

  always_comb begin
    op         = op_e'(cmd_op);
    accept     = cmd_valid && !pend;
    full       = top[ADDR_W];
    list_empty = (head == NIL_A);
  end

  // Single write port and single registered read port. A reuse ALLOC reads
  // the head cell's link in the accept cycle, then writes the payload into
  // that cell on the following cycle.
  always_comb begin
    mem_we = 1'b0;
    mem_re = 1'b0;
    mem_wa = cmd_addr;
    mem_ra = cmd_addr;
    mem_wd = cmd_data;
    if (pend) begin
      mem_we = 1'b1;
      mem_wa = pend_addr;
      mem_wd = pend_data;
    end else if (accept) begin
      case (op)
        OP_ALLOC: begin
          if (!list_empty) begin
            mem_re = 1'b1;
            mem_ra = head;
          end else if (!full) begin
            mem_we = 1'b1;
            mem_wa = top[ADDR_W-1:0];
          end
        end
        OP_FREE: begin
          mem_we = 1'b1;
          mem_wd = DATA_W'(head);
        end
        OP_READ:  mem_re = 1'b1;
        OP_WRITE: mem_we = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
    if (mem_re) mem_q <= mem[mem_ra];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= NIL_A;
      top       <= TOP_ONE;
      pend      <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
      rsp_valid <= 1'b0;
      rsp_addr  <= NIL_A;
    end else begin
      rsp_valid <= 1'b0;
      if (pend) begin
        head      <= mem_q[ADDR_W-1:0];
        pend      <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_addr  <= pend_addr;
      end else if (accept) begin
        rsp_valid <= 1'b1;
        case (op)
          OP_ALLOC: begin
            if (!list_empty) begin
              pend      <= 1'b1;
              pend_addr <= head;
              pend_data <= cmd_data;
              rsp_valid <= 1'b0;
            end else if (!full) begin
              rsp_addr <= top[ADDR_W-1:0];
              top      <= top + TOP_ONE;
            end else begin
              rsp_addr <= NIL_A;
            end
          end
          OP_FREE: head <= cmd_addr;
          default: ;
        endcase
      end
    end
  end

  assign ready    = !pend;
  assign rsp_data = mem_q;

endmodule

// File: rtl/alloc_test.sv
// alloc_test: scripted self-test of the alloc free-list allocator.
// Ports:
//   i_clk      system clock (rising edge)
//   i_rst      synchronous active-high reset
//   i_en       run enable; the script holds its state while low
//   o_running  script enabled and not yet passed or errored
//   o_debug    [63:56] step, [55:48] FSM state, [47:32] last ALLOC address,
//              [31:0] last READ data
//   o_passed   sticky: all steps matched
//   o_error    sticky: a step mismatched; the script halts on that step
module alloc_test
  import alloc_test_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  output logic        o_running,
  output logic [63:0] o_debug,
  output logic        o_passed,
  output logic        o_error
);

  localparam logic [ADDR_W-1:0] NIL_A = ADDR_W'(NIL);

  state_e            state;
  state_e            state_nx;
  logic [3:0]        step;
  step_t             cur;
  logic              match;

  logic              cmd_valid;
  logic              ready;
  logic              rsp_valid;
  logic [ADDR_W-1:0] rsp_addr;
  logic [DATA_W-1:0] rsp_data;

  // Result latch: captures the allocator response even while i_en is low so
  // that a paused step is checked once enable returns.
  logic              res_valid;
  logic [ADDR_W-1:0] res_addr;
  logic [DATA_W-1:0] res_data;

  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_data;

  always_comb begin
    cur       = script_step(step);
    cmd_valid = (state == S_ISSUE) && i_en && ready;
  end

  alloc #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_alloc (
    .clk      (i_clk),
    .rst      (i_rst),
    .cmd_valid(cmd_valid),
    .cmd_op   (cur.op),
    .cmd_addr (ADDR_W'(cur.addr)),
    .cmd_data (DATA_W'(cur.data)),
    .ready    (ready),
    .rsp_valid(rsp_valid),
    .rsp_addr (rsp_addr),
    .rsp_data (rsp_data)
  );

  always_comb begin
    match = 1'b1;
    case (cur.op)
      OP_ALLOC: match = (res_addr != NIL_A) && (res_addr == ADDR_W'(cur.exp));
      OP_READ:  match = (res_data == DATA_W'(cur.exp));
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (i_en) state_nx = S_ISSUE;
      S_ISSUE: if (cmd_valid) state_nx = S_WAIT;
      S_WAIT:  if (i_en && res_valid) state_nx = S_CHECK;
      S_CHECK: begin
        if (i_en) begin
          if (!match)                                state_nx = S_FAIL;
          else if (step == 4'(NUM_STEPS - 1))        state_nx = S_DONE;
          else                                       state_nx = S_ISSUE;
        end
      end
      S_DONE:  state_nx = S_DONE;
      S_FAIL:  state_nx = S_FAIL;
      default: state_nx = S_IDLE;
    endcase
  end

  // Step counter, result latch and debug capture
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      step      <= '0;
      res_valid <= 1'b0;
      res_addr  <= '0;
      res_data  <= '0;
      last_addr <= '0;
      last_data <= '0;
    end else begin
      if (cmd_valid) begin
        res_valid <= 1'b0;
      end else if (rsp_valid) begin
        res_valid <= 1'b1;
        res_addr  <= rsp_addr;
        res_data  <= rsp_data;
      end
      if (state == S_CHECK && i_en) begin
        if (cur.op == OP_ALLOC) last_addr <= res_addr;
        if (cur.op == OP_READ)  last_data <= res_data;
        // Step stays put on mismatch so the debug port names the failing step.
        if (match) step <= step + 4'd1;
      end
    end
  end

  // Outputs
  always_comb begin
    o_passed  = (state == S_DONE);
    o_error   = (state == S_FAIL);
    o_running = i_en && !i_rst && (state != S_DONE) && (state != S_FAIL);
    o_debug   = '0;
    o_debug[DBG_STEP_LSB  +: 8]  = 8'(step);
    o_debug[DBG_STATE_LSB +: 8]  = 8'(state);
    o_debug[DBG_ADDR_LSB  +: 16] = 16'(last_addr);
    o_debug[DBG_DATA_LSB  +: 32] = 32'(last_data);
  end

endmodule

// File: tb/tb_alloc_test.sv
module tb_alloc_test;
  import alloc_test_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en;
  logic        running;
  logic        passed;
  logic        error;
  logic [63:0] debug;

  alloc_test #(
    .ADDR_W(8),
    .DATA_W(32)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_en     (en),
    .o_running(running),
    .o_debug  (debug),
    .o_passed (passed),
    .o_error  (error)
  );

  logic        s_rst;
  logic        s_cmd_valid;
  logic [2:0]  s_cmd_op;
  logic [1:0]  s_cmd_addr;
  logic [31:0] s_cmd_data;
  logic        s_ready;
  logic        s_rsp_valid;
  logic [1:0]  s_rsp_addr;
  logic [31:0] s_rsp_data;

  alloc #(
    .ADDR_W(2),
    .DATA_W(32)
  ) u_small (
    .clk      (clk),
    .rst      (s_rst),
    .cmd_valid(s_cmd_valid),
    .cmd_op   (s_cmd_op),
    .cmd_addr (s_cmd_addr),
    .cmd_data (s_cmd_data),
    .ready    (s_ready),
    .rsp_valid(s_rsp_valid),
    .rsp_addr (s_rsp_addr),
    .rsp_data (s_rsp_data)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          step;
    bit          is_addr;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] sq[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected result of every checked step, consumed as the step index advances.
  task automatic load_sb;
    sb.delete();
    sb.push_back('{0, 1'b1, 32'h0000_0001});
    sb.push_back('{1, 1'b1, 32'h0000_0002});
    sb.push_back('{2, 1'b0, 32'h1111_1111});
    sb.push_back('{4, 1'b1, 32'h0000_0001});
    sb.push_back('{5, 1'b1, 32'h0000_0003});
    sb.push_back('{6, 1'b0, 32'h2222_2222});
    sb.push_back('{7, 1'b0, 32'h3333_3333});
    sb.push_back('{9, 1'b0, 32'h5555_5555});
  endtask

  // mode 0: plain run; 1: drop i_en for 5 cycles in step 4 WAIT;
  // 2: corrupt mem[2] as step 6 begins; 3: return once step 5 is reached.
  task automatic run_script(input int mode, input int budget);
    int   prev;
    int   cur;
    int   cyc;
    bit   fin;
    bit   paused;
    bit   corrupted;
    exp_t e;
    prev = 0; cyc = 0; fin = 0; paused = 0; corrupted = 0;
    while (!fin && cyc < budget) begin
      tick;
      cyc++;
      cur = int'(debug[63:56]);
      if (cur != prev) begin
        if (sb.size() > 0 && sb[0].step == prev) begin
          e = sb.pop_front();
          if (e.is_addr)
            chk($sformatf("step%0d_addr", prev), 64'(debug[47:32]), 64'(e.val));
          else
            chk($sformatf("step%0d_data", prev), 64'(debug[31:0]), 64'(e.val));
        end
        prev = cur;
      end
      if (mode == 1 && !paused && cur == 4 && debug[55:48] === 8'(S_WAIT)) begin
        paused = 1;
        en = 1'b0;
        repeat (5) tick;
        chk("pause_running", 64'(running), 64'(0));
        chk("pause_step", 64'(debug[63:56]), 64'(4));
        en = 1'b1;
      end
      if (mode == 2 && !corrupted && cur == 6) begin
        dut.u_alloc.mem[2] = 32'hDEAD_BEEF;
        corrupted = 1;
      end
      if (mode == 3 && cur == 5) fin = 1;
      if (passed || error) fin = 1;
    end
    if (!fin) chk("run_budget", 64'(passed | error), 64'(1));
  endtask

  task automatic small_cmd(input logic [2:0] op, input logic [1:0] a,
                           input logic [31:0] d, output int lat);
    int w;
    w = 0;
    while (!s_ready && w < 8) begin
      tick;
      w++;
    end
    s_cmd_valid = 1'b1;
    s_cmd_op    = op;
    s_cmd_addr  = a;
    s_cmd_data  = d;
    tick;
    s_cmd_valid = 1'b0;
    lat = 1;
    while (!s_rsp_valid && lat < 6) begin
      tick;
      lat++;
    end
  endtask

  task automatic small_alloc(input string tag, input logic [31:0] d,
                             input logic [31:0] exp_addr, input int exp_lat);
    int          lat;
    logic [31:0] e;
    sq.push_back(exp_addr);
    small_cmd(3'(OP_ALLOC), 2'd0, d, lat);
    chk({tag, "_valid"}, 64'(s_rsp_valid), 64'(1));
    e = sq.pop_front();
    chk({tag, "_addr"}, 64'(s_rsp_addr), 64'(e));
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
  endtask

  initial begin
    int lat;
    rst         = 1'b1;
    en          = 1'b0;
    s_rst       = 1'b1;
    s_cmd_valid = 1'b0;
    s_cmd_op    = '0;
    s_cmd_addr  = '0;
    s_cmd_data  = '0;
    tick;
    tick;
    chk("reset_debug", debug, 64'h0);
    chk("reset_passed", 64'(passed), 64'(0));
    chk("reset_error", 64'(error), 64'(0));
    chk("reset_running", 64'(running), 64'(0));
    rst = 1'b0;

    repeat (3) tick;
    chk("idle_running", 64'(running), 64'(0));
    chk("idle_debug", debug, 64'h0);

    // Plain run
    en = 1'b1;
    #1;
    chk("first_en_running", 64'(running), 64'(1));
    load_sb();
    run_script(0, 60);
    chk("run0_passed", 64'(passed), 64'(1));
    chk("run0_error", 64'(error), 64'(0));
    chk("run0_running", 64'(running), 64'(0));
    chk("run0_step", 64'(debug[63:56]), 64'h0A);

    // Enable dropped while the reuse ALLOC is in flight
    rst = 1'b1;
    tick;
    rst = 1'b0;
    load_sb();
    run_script(1, 80);
    chk("pause_passed", 64'(passed), 64'(1));
    chk("pause_final_step", 64'(debug[63:56]), 64'h0A);

    // Corrupted cell 2 must stop the script at step 6
    rst = 1'b1;
    tick;
    rst = 1'b0;
    load_sb();
    run_script(2, 80);
    chk("corrupt_error", 64'(error), 64'(1));
    chk("corrupt_passed", 64'(passed), 64'(0));
    chk("corrupt_running", 64'(running), 64'(0));
    chk("corrupt_step", 64'(debug[63:56]), 64'h06);
    chk("corrupt_data", 64'(debug[31:0]), 64'hDEAD_BEEF);

    // Reset mid-script, then a full rerun
    rst = 1'b1;
    tick;
    rst = 1'b0;
    load_sb();
    run_script(3, 60);
    chk("midrst_at_step5", 64'(debug[63:56]), 64'h05);
    rst = 1'b1;
    tick;
    chk("midrst_debug", debug, 64'h0);
    chk("midrst_running", 64'(running), 64'(0));
    chk("midrst_passed", 64'(passed), 64'(0));
    chk("midrst_error", 64'(error), 64'(0));
    rst = 1'b0;
    load_sb();
    run_script(0, 60);
    chk("rerun_passed", 64'(passed), 64'(1));
    chk("rerun_sb_drained", 64'(sb.size()), 64'(0));

    // Standalone allocator with 4 cells (3 usable)
    s_rst = 1'b1;
    tick;
    s_rst = 1'b0;
    chk("s_reset_ready", 64'(s_ready), 64'(1));
    chk("s_reset_valid", 64'(s_rsp_valid), 64'(0));
    small_alloc("s_alloc1", 32'hA000_0001, 32'd1, 1);
    small_alloc("s_alloc2", 32'hA000_0002, 32'd2, 1);
    small_alloc("s_alloc3", 32'hA000_0003, 32'd3, 1);
    small_alloc("s_alloc_full", 32'hA000_0004, 32'd0, 1);
    small_cmd(3'(OP_FREE), 2'd2, 32'h0, lat);
    chk("s_free_ack", 64'(s_rsp_valid), 64'(1));
    small_alloc("s_reuse", 32'hA000_0005, 32'd2, 2);
    small_cmd(3'(OP_READ), 2'd2, 32'h0, lat);
    chk("s_read2", 64'(s_rsp_data), 64'hA000_0005);
    small_cmd(3'(OP_READ), 2'd3, 32'h0, lat);
    chk("s_read3", 64'(s_rsp_data), 64'hA000_0003);
    small_alloc("s_alloc_full2", 32'hA000_0006, 32'd0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
